decode_mmu_fault_ctrl: RTL and testbench

- Registered decode-entry stage that checks each fetched instruction's MMU flags against paging and privilege state.
- Clean instructions pass downstream with 1-cycle latency.
- On the first faulting instruction: drop it, raise a single exception request (IRQ40/41/42) toward the exception manager, and stall the fetch→decode path until acknowledge plus pipeline flush.
- Sits between the fetch queue output and the decoder.

---
 rtl/decode_mmu_fault_ctrl.sv | 127 ++++++++++++
 tb/tb_decode_mmu_fault_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_mmu_fault_ctrl.sv
// Decode-entry stage: forwards clean fetched instructions with one cycle of latency
// and turns the first MMU-flag violation into a single held exception request.
module decode_mmu_fault_ctrl #(
  parameter logic [6:0]  IRQ_PAGE_FAULT = 7'd40,
  parameter logic [6:0]  IRQ_PRIV_ERR   = 7'd41,
  parameter logic [6:0]  IRQ_INV_INST   = 7'd42,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iRESET_SYNC,
  input  logic             iFLUSH,
  input  logic             iPAGING_ENA,
  input  logic             iKERNEL_ACCESS,
  input  logic             iPREVIOUS_VALID,
  output logic             oPREVIOUS_LOCK,
  input  logic [31:0]      iPREVIOUS_INST,
  input  logic [31:0]      iPREVIOUS_PC,
  input  logic [13:0]      iPREVIOUS_MMU_FLAGS,
  output logic             oNEXT_VALID,
  input  logic             iNEXT_LOCK,
  output logic [31:0]      oNEXT_INST,
  output logic [31:0]      oNEXT_PC,
  output logic             oFAULT_REQ,
  output logic [6:0]       oFAULT_IRQ,
  output logic [31:0]      oFAULT_PC,
  input  logic             iFAULT_ACK,
  output logic [CNT_W-1:0] oFAULT_COUNT
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REQ,
    ST_HALT
  } state_t;

  state_t     state;
  logic       accept;
  logic       fault;
  logic [6:0] fault_irq;
  logic       unused_flags;

  assign unused_flags = ^iPREVIOUS_MMU_FLAGS[13:6];

  assign oPREVIOUS_LOCK = (state != ST_RUN) || (oNEXT_VALID && iNEXT_LOCK);
  assign accept         = iPREVIOUS_VALID && !oPREVIOUS_LOCK;

  always_comb begin
    fault     = 1'b0;
    fault_irq = '0;
    if (iPAGING_ENA) begin
      if (!iPREVIOUS_MMU_FLAGS[0]) begin
        fault     = 1'b1;
        fault_irq = IRQ_PAGE_FAULT;
      end else if (!iPREVIOUS_MMU_FLAGS[3]) begin
        fault     = 1'b1;
        fault_irq = IRQ_INV_INST;
      end else if (!iKERNEL_ACCESS && (iPREVIOUS_MMU_FLAGS[5:4] == 2'b00)) begin
        fault     = 1'b1;
        fault_irq = IRQ_PRIV_ERR;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state        <= ST_RUN;
      oNEXT_VALID  <= 1'b0;
      oNEXT_INST   <= '0;
      oNEXT_PC     <= '0;
      oFAULT_REQ   <= 1'b0;
      oFAULT_IRQ   <= '0;
      oFAULT_PC    <= '0;
      oFAULT_COUNT <= '0;
    end else if (iRESET_SYNC) begin
      state        <= ST_RUN;
      oNEXT_VALID  <= 1'b0;
      oNEXT_INST   <= '0;
      oNEXT_PC     <= '0;
      oFAULT_REQ   <= 1'b0;
      oFAULT_IRQ   <= '0;
      oFAULT_PC    <= '0;
      oFAULT_COUNT <= '0;
    end else if (iFLUSH) begin
      state       <= ST_RUN;
      oNEXT_VALID <= 1'b0;
      oFAULT_REQ  <= 1'b0;
      // An ack coinciding with the flush still counts as a delivered fault.
      if ((state == ST_REQ) && iFAULT_ACK && (oFAULT_COUNT != '1)) begin
        oFAULT_COUNT <= oFAULT_COUNT + CNT_W'(1);
      end
    end else begin
      // Output beat drains in every state; a newly accepted clean beat overrides below.
      if (!iNEXT_LOCK) begin
        oNEXT_VALID <= 1'b0;
      end
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (fault) begin
              oFAULT_REQ <= 1'b1;
              oFAULT_IRQ <= fault_irq;
              oFAULT_PC  <= iPREVIOUS_PC;
              state      <= ST_REQ;
            end else begin
              oNEXT_VALID <= 1'b1;
              oNEXT_INST  <= iPREVIOUS_INST;
              oNEXT_PC    <= iPREVIOUS_PC;
            end
          end
        end
        ST_REQ: begin
          if (iFAULT_ACK) begin
            oFAULT_REQ <= 1'b0;
            state      <= ST_HALT;
            if (oFAULT_COUNT != '1) begin
              oFAULT_COUNT <= oFAULT_COUNT + CNT_W'(1);
            end
          end
        end
        ST_HALT: ;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_mmu_fault_ctrl.sv
// Bench for decode_mmu_fault_ctrl: forwarded beats are checked against a queue of
// expected beats; fault request, IRQ, PC, count and stall behaviour are checked inline.
module tb_decode_mmu_fault_ctrl;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iRESET_SYNC;
  logic        iFLUSH;
  logic        iPAGING_ENA;
  logic        iKERNEL_ACCESS;
  logic        iPREVIOUS_VALID;
  logic        oPREVIOUS_LOCK;
  logic [31:0] iPREVIOUS_INST;
  logic [31:0] iPREVIOUS_PC;
  logic [13:0] iPREVIOUS_MMU_FLAGS;
  logic        oNEXT_VALID;
  logic        iNEXT_LOCK;
  logic [31:0] oNEXT_INST;
  logic [31:0] oNEXT_PC;
  logic        oFAULT_REQ;
  logic [6:0]  oFAULT_IRQ;
  logic [31:0] oFAULT_PC;
  logic        iFAULT_ACK;
  logic [7:0]  oFAULT_COUNT;

  decode_mmu_fault_ctrl #(
    .IRQ_PAGE_FAULT(7'd40),
    .IRQ_PRIV_ERR  (7'd41),
    .IRQ_INV_INST  (7'd42),
    .CNT_W         (8)
  ) dut (
    .iCLOCK             (iCLOCK),
    .inRESET            (inRESET),
    .iRESET_SYNC        (iRESET_SYNC),
    .iFLUSH             (iFLUSH),
    .iPAGING_ENA        (iPAGING_ENA),
    .iKERNEL_ACCESS     (iKERNEL_ACCESS),
    .iPREVIOUS_VALID    (iPREVIOUS_VALID),
    .oPREVIOUS_LOCK     (oPREVIOUS_LOCK),
    .iPREVIOUS_INST     (iPREVIOUS_INST),
    .iPREVIOUS_PC       (iPREVIOUS_PC),
    .iPREVIOUS_MMU_FLAGS(iPREVIOUS_MMU_FLAGS),
    .oNEXT_VALID        (oNEXT_VALID),
    .iNEXT_LOCK         (iNEXT_LOCK),
    .oNEXT_INST         (oNEXT_INST),
    .oNEXT_PC           (oNEXT_PC),
    .oFAULT_REQ         (oFAULT_REQ),
    .oFAULT_IRQ         (oFAULT_IRQ),
    .oFAULT_PC          (oFAULT_PC),
    .iFAULT_ACK         (iFAULT_ACK),
    .oFAULT_COUNT       (oFAULT_COUNT)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } beat_t;

  beat_t      exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_cnt     = 8'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_irq(input logic paging, input logic kern,
                                           input logic [13:0] f);
    if (!paging)                      return 7'd0;
    if (!f[0])                        return 7'd40;
    if (!f[3])                        return 7'd42;
    if (!kern && (f[5:4] == 2'b00))   return 7'd41;
    return 7'd0;
  endfunction

  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] inst, input logic [31:0] pc,
                            input logic [13:0] flags, input logic kern, input bit push);
    beat_t b;
    iPREVIOUS_VALID     = 1'b1;
    iPREVIOUS_INST      = inst;
    iPREVIOUS_PC        = pc;
    iPREVIOUS_MMU_FLAGS = flags;
    iKERNEL_ACCESS      = kern;
    if (push && model_irq(iPAGING_ENA, kern, flags) == 7'd0) begin
      b.inst = inst;
      b.pc   = pc;
      exp_q.push_back(b);
    end
  endtask

  // Consumer side: a beat is taken whenever valid is presented with no downstream stall.
  always @(negedge iCLOCK) begin
    if (inRESET && oNEXT_VALID && !iNEXT_LOCK) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_beat", oNEXT_PC, 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check_eq("out_inst", oNEXT_INST, b.inst);
        check_eq("out_pc", oNEXT_PC, b.pc);
      end
    end
  end

  task automatic do_fault(input logic [31:0] pc, input logic [13:0] flags,
                          input logic kern, input logic [6:0] exp_irq);
    drive_beat(32'hDEAD_0000 ^ pc, pc, flags, kern, 1'b1);
    step();
    iPREVIOUS_VALID = 1'b0;
    check_eq("req_set", oFAULT_REQ, 1);
    check_eq("req_irq", oFAULT_IRQ, exp_irq);
    check_eq("req_pc", oFAULT_PC, pc);
    check_eq("req_nofwd", oNEXT_VALID, 0);
    check_eq("req_lock", oPREVIOUS_LOCK, 1);
    step();
    check_eq("req_hold", oFAULT_REQ, 1);
    check_eq("req_hold_irq", oFAULT_IRQ, exp_irq);
    iFAULT_ACK = 1'b1;
    step();
    iFAULT_ACK = 1'b0;
    if (exp_cnt != 8'hFF) exp_cnt++;
    check_eq("ack_req", oFAULT_REQ, 0);
    check_eq("ack_count", oFAULT_COUNT, exp_cnt);
    check_eq("halt_lock", oPREVIOUS_LOCK, 1);
    // Beat offered during HALT and the flush cycle must never be accepted.
    drive_beat(32'h1111_1111, pc + 32'h4, 14'h3F, 1'b1, 1'b0);
    iFLUSH = 1'b1;
    step();
    iFLUSH          = 1'b0;
    iPREVIOUS_VALID = 1'b0;
    check_eq("flush_run", oPREVIOUS_LOCK, 0);
    check_eq("flush_valid", oNEXT_VALID, 0);
    check_eq("flush_irq_hold", oFAULT_IRQ, exp_irq);
  endtask

  initial begin
    inRESET             = 1'b0;
    iRESET_SYNC         = 1'b0;
    iFLUSH              = 1'b0;
    iPAGING_ENA         = 1'b0;
    iKERNEL_ACCESS      = 1'b0;
    iPREVIOUS_VALID     = 1'b0;
    iPREVIOUS_INST      = '0;
    iPREVIOUS_PC        = '0;
    iPREVIOUS_MMU_FLAGS = '0;
    iNEXT_LOCK          = 1'b0;
    iFAULT_ACK          = 1'b0;
    step();
    step();
    check_eq("rst_valid", oNEXT_VALID, 0);
    check_eq("rst_req", oFAULT_REQ, 0);
    check_eq("rst_count", oFAULT_COUNT, 0);
    check_eq("rst_lock", oPREVIOUS_LOCK, 0);
    inRESET = 1'b1;
    step();

    // Paging off: flags ignored, four back-to-back beats, one cycle of latency each.
    for (int i = 0; i < 4; i++) begin
      drive_beat(32'hA000_0000 + i, 32'h100 + 32'(4 * i), 14'h0, 1'b0, 1'b1);
      step();
      check_eq("lat_valid", oNEXT_VALID, 1);
      check_eq("lat_pc", oNEXT_PC, 32'h100 + 32'(4 * i));
      check_eq("lat_noreq", oFAULT_REQ, 0);
    end
    iPREVIOUS_VALID = 1'b0;
    step();
    check_eq("idle_valid", oNEXT_VALID, 0);

    // Paging on: each fault class and its priority.
    iPAGING_ENA = 1'b1;
    do_fault(32'h2000, 14'h0000, 1'b0, 7'd40);
    do_fault(32'h3000, 14'h0001, 1'b0, 7'd42);
    do_fault(32'h3100, 14'h0009, 1'b0, 7'd41);
    do_fault(32'h3200, 14'h0030, 1'b1, 7'd40);
    do_fault(32'h3300, 14'h3FC9, 1'b0, 7'd41);

    // Clean under paging: kernel bypasses privilege check, user with flags[4] set.
    drive_beat(32'hB000_0001, 32'h5000, 14'h0009, 1'b1, 1'b1);
    step();
    check_eq("kern_clean", oNEXT_VALID, 1);
    drive_beat(32'hB000_0002, 32'h5004, 14'h0019, 1'b0, 1'b1);
    step();
    check_eq("user_clean", oNEXT_PC, 32'h5004);
    check_eq("user_noreq", oFAULT_REQ, 0);
    iPREVIOUS_VALID = 1'b0;
    step();

    // Downstream stall: output holds, upstream locked, no beat lost.
    iNEXT_LOCK = 1'b1;
    drive_beat(32'hC000_000A, 32'h6000, 14'h0009, 1'b1, 1'b1);
    step();
    drive_beat(32'hC000_000B, 32'h6004, 14'h0009, 1'b1, 1'b0);
    check_eq("stall_lock", oPREVIOUS_LOCK, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_pc", oNEXT_PC, 32'h6000);
      check_eq("stall_valid", oNEXT_VALID, 1);
      check_eq("stall_lock_hold", oPREVIOUS_LOCK, 1);
    end
    iNEXT_LOCK = 1'b0;
    begin
      beat_t b;
      b.inst = 32'hC000_000B;
      b.pc   = 32'h6004;
      exp_q.push_back(b);
    end
    step();
    iPREVIOUS_VALID = 1'b0;
    check_eq("release_pc", oNEXT_PC, 32'h6004);
    check_eq("release_inst", oNEXT_INST, 32'hC000_000B);
    step();

    // Ack together with flush in REQ.
    drive_beat(32'hD000_0000, 32'h7000, 14'h0000, 1'b0, 1'b1);
    step();
    iPREVIOUS_VALID = 1'b0;
    check_eq("af_req", oFAULT_REQ, 1);
    iFAULT_ACK = 1'b1;
    iFLUSH     = 1'b1;
    step();
    iFAULT_ACK = 1'b0;
    iFLUSH     = 1'b0;
    if (exp_cnt != 8'hFF) exp_cnt++;
    check_eq("af_req_clr", oFAULT_REQ, 0);
    check_eq("af_count", oFAULT_COUNT, exp_cnt);
    check_eq("af_run", oPREVIOUS_LOCK, 0);

    // Flush drops a stalled valid output.
    iNEXT_LOCK = 1'b1;
    drive_beat(32'hE000_0000, 32'h8000, 14'h0009, 1'b1, 1'b1);
    step();
    iPREVIOUS_VALID = 1'b0;
    check_eq("fv_valid", oNEXT_VALID, 1);
    iFLUSH = 1'b1;
    step();
    iFLUSH = 1'b0;
    check_eq("fv_cleared", oNEXT_VALID, 0);
    void'(exp_q.pop_front());
    iNEXT_LOCK = 1'b0;

    // Beat offered in a RUN-state flush cycle is discarded.
    iFLUSH = 1'b1;
    drive_beat(32'hE000_0001, 32'h8004, 14'h0009, 1'b1, 1'b0);
    step();
    iFLUSH          = 1'b0;
    iPREVIOUS_VALID = 1'b0;
    check_eq("fr_discard", oNEXT_VALID, 0);
    step();

    // Saturation of the fault counter.
    for (int i = 0; i < 256; i++) begin
      do_fault(32'h9000 + 32'(i), 14'h0000, 1'b0, 7'd40);
    end
    check_eq("sat_count", oFAULT_COUNT, 8'hFF);

    // Asynchronous reset mid-REQ.
    drive_beat(32'hF000_0000, 32'hA000, 14'h0001, 1'b0, 1'b1);
    step();
    iPREVIOUS_VALID = 1'b0;
    check_eq("ar_req_pre", oFAULT_REQ, 1);
    #1 inRESET = 1'b0;
    #1;
    check_eq("ar_req", oFAULT_REQ, 0);
    check_eq("ar_irq", oFAULT_IRQ, 0);
    check_eq("ar_pc", oFAULT_PC, 0);
    check_eq("ar_count", oFAULT_COUNT, 0);
    check_eq("ar_valid", oNEXT_VALID, 0);
    check_eq("ar_lock", oPREVIOUS_LOCK, 0);
    #4 inRESET = 1'b1;
    exp_cnt = 8'd0;
    step();

    // Synchronous clear wins over flush.
    do_fault(32'hB000, 14'h0000, 1'b0, 7'd40);
    iRESET_SYNC = 1'b1;
    iFLUSH      = 1'b1;
    step();
    iRESET_SYNC = 1'b0;
    iFLUSH      = 1'b0;
    exp_cnt     = 8'd0;
    check_eq("rs_count", oFAULT_COUNT, 0);
    check_eq("rs_irq", oFAULT_IRQ, 0);
    check_eq("rs_pc", oFAULT_PC, 0);
    check_eq("rs_lock", oPREVIOUS_LOCK, 0);

    step();
    check_eq("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
